// File: rtl/bp_nonsynth_commit_aligner.sv
// Reorders commit and writeback streams into in-order records: commits are queued,
// register writes fill their data later, and the head is presented once complete.
module bp_nonsynth_commit_aligner #(
  parameter int vaddr_width_p = 39,
  parameter int instr_width_p = 32,
  parameter int dword_width_p = 64,
  parameter int els_p         = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     commit_v_i,
  input  logic [vaddr_width_p-1:0] commit_pc_i,
  input  logic [instr_width_p-1:0] commit_instr_i,
  input  logic                     commit_rd_w_v_i,
  input  logic                     commit_fp_i,
  input  logic [4:0]               commit_rd_addr_i,
  input  logic                     interrupt_v_i,
  input  logic [dword_width_p-1:0] cause_i,
  input  logic                     int_wb_v_i,
  input  logic [4:0]               int_wb_addr_i,
  input  logic [dword_width_p-1:0] int_wb_data_i,
  input  logic                     fp_wb_v_i,
  input  logic [4:0]               fp_wb_addr_i,
  input  logic [dword_width_p-1:0] fp_wb_data_i,
  output logic                     rec_v_o,
  input  logic                     rec_ready_i,
  output logic [vaddr_width_p-1:0] rec_pc_o,
  output logic [instr_width_p-1:0] rec_instr_o,
  output logic [dword_width_p-1:0] rec_wdata_o,
  output logic                     rec_trap_o,
  output logic [dword_width_p-1:0] rec_cause_o,
  output logic                     full_o,
  output logic                     overflow_o,
  output logic                     orphan_o
);

  localparam int AW = $clog2(els_p);
  localparam int PW = AW + 1;

  logic [vaddr_width_p-1:0] r_pc    [els_p];
  logic [instr_width_p-1:0] r_instr [els_p];
  logic [dword_width_p-1:0] r_wdata [els_p];
  logic [dword_width_p-1:0] r_cause [els_p];
  logic [4:0]               r_rd    [els_p];
  logic [els_p-1:0]         r_done;
  logic [els_p-1:0]         r_trap;
  logic [els_p-1:0]         r_fp;
  logic [PW-1:0]            r_wr_ptr;
  logic [PW-1:0]            r_rd_ptr;
  logic                     r_overflow;
  logic                     r_orphan;

  logic [PW-1:0] w_count;
  logic [AW-1:0] w_head;
  logic [AW-1:0] w_wr_idx;
  logic          w_empty;
  logic          w_full;
  logic          w_event;
  logic          w_enq;
  logic          w_new_wait;
  logic          w_int_old_v;
  logic [AW-1:0] w_int_old_idx;
  logic          w_fp_old_v;
  logic [AW-1:0] w_fp_old_idx;
  logic          w_int_new;
  logic          w_fp_new;
  logic          w_retire;

  assign w_count  = r_wr_ptr - r_rd_ptr;
  assign w_head   = r_rd_ptr[AW-1:0];
  assign w_wr_idx = r_wr_ptr[AW-1:0];
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  assign w_event    = commit_v_i | interrupt_v_i;
  assign w_enq      = w_event & ~w_full;
  // Integer x0 never produces a writeback, so it completes on enqueue.
  assign w_new_wait = ~interrupt_v_i & commit_rd_w_v_i & (commit_fp_i | (commit_rd_addr_i != 5'd0));

  // Scan youngest-to-oldest so the last hit recorded is the oldest waiting entry.
  always_comb begin
    w_int_old_v   = 1'b0;
    w_int_old_idx = '0;
    w_fp_old_v    = 1'b0;
    w_fp_old_idx  = '0;
    for (int i = els_p - 1; i >= 0; i--) begin
      if ((PW'(i) < w_count) && !r_done[w_head + AW'(i)]) begin
        if (int_wb_v_i && !r_fp[w_head + AW'(i)] && (r_rd[w_head + AW'(i)] == int_wb_addr_i)) begin
          w_int_old_v   = 1'b1;
          w_int_old_idx = w_head + AW'(i);
        end
        if (fp_wb_v_i && r_fp[w_head + AW'(i)] && (r_rd[w_head + AW'(i)] == fp_wb_addr_i)) begin
          w_fp_old_v   = 1'b1;
          w_fp_old_idx = w_head + AW'(i);
        end
      end
    end
  end

  assign w_int_new = int_wb_v_i & ~w_int_old_v & w_enq & w_new_wait & ~commit_fp_i
                   & (commit_rd_addr_i == int_wb_addr_i);
  assign w_fp_new  = fp_wb_v_i & ~w_fp_old_v & w_enq & w_new_wait & commit_fp_i
                   & (commit_rd_addr_i == fp_wb_addr_i);

  assign rec_v_o     = ~w_empty & r_done[w_head];
  assign w_retire    = rec_v_o & rec_ready_i;
  assign rec_pc_o    = rec_v_o ? r_pc[w_head]    : '0;
  assign rec_instr_o = rec_v_o ? r_instr[w_head] : '0;
  assign rec_wdata_o = rec_v_o ? r_wdata[w_head] : '0;
  assign rec_cause_o = rec_v_o ? r_cause[w_head] : '0;
  assign rec_trap_o  = rec_v_o & r_trap[w_head];
  assign full_o      = w_full;
  assign overflow_o  = r_overflow;
  assign orphan_o    = r_orphan;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
      r_orphan   <= 1'b0;
      r_done     <= '0;
      r_trap     <= '0;
      r_fp       <= '0;
      for (int i = 0; i < els_p; i++) begin
        r_pc[i]    <= '0;
        r_instr[i] <= '0;
        r_wdata[i] <= '0;
        r_cause[i] <= '0;
        r_rd[i]    <= '0;
      end
    end else begin
      if (w_enq) begin
        r_wr_ptr           <= r_wr_ptr + PW'(1);
        r_pc[w_wr_idx]     <= commit_pc_i;
        r_instr[w_wr_idx]  <= commit_instr_i;
        r_trap[w_wr_idx]   <= interrupt_v_i;
        r_cause[w_wr_idx]  <= interrupt_v_i ? cause_i : '0;
        r_rd[w_wr_idx]     <= commit_rd_addr_i;
        r_fp[w_wr_idx]     <= commit_fp_i;
        r_done[w_wr_idx]   <= ~w_new_wait | w_int_new | w_fp_new;
        r_wdata[w_wr_idx]  <= w_int_new ? int_wb_data_i : (w_fp_new ? fp_wb_data_i : '0);
      end
      if (w_int_old_v) begin
        r_done[w_int_old_idx]  <= 1'b1;
        r_wdata[w_int_old_idx] <= int_wb_data_i;
      end
      if (w_fp_old_v) begin
        r_done[w_fp_old_idx]  <= 1'b1;
        r_wdata[w_fp_old_idx] <= fp_wb_data_i;
      end
      if (w_retire) r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_event & w_full) r_overflow <= 1'b1;
      if ((int_wb_v_i & ~w_int_old_v & ~w_int_new) | (fp_wb_v_i & ~w_fp_old_v & ~w_fp_new))
        r_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bp_nonsynth_commit_aligner.sv
// Bench for the commit aligner: directed scenarios plus randomized traffic against a queue model.
module tb_bp_nonsynth_commit_aligner;
  localparam int VA = 39;
  localparam int IW = 32;
  localparam int DW = 64;
  localparam int ELS = 8;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b0;
  logic          commit_v_i, commit_rd_w_v_i, commit_fp_i, interrupt_v_i;
  logic [VA-1:0] commit_pc_i;
  logic [IW-1:0] commit_instr_i;
  logic [4:0]    commit_rd_addr_i, int_wb_addr_i, fp_wb_addr_i;
  logic [DW-1:0] cause_i, int_wb_data_i, fp_wb_data_i;
  logic          int_wb_v_i, fp_wb_v_i, rec_ready_i;
  logic          rec_v_o, rec_trap_o, full_o, overflow_o, orphan_o;
  logic [VA-1:0] rec_pc_o;
  logic [IW-1:0] rec_instr_o;
  logic [DW-1:0] rec_wdata_o, rec_cause_o;

  int n_checks = 0;
  int n_pass = 0;

  typedef struct packed {
    logic [VA-1:0] pc;
    logic [IW-1:0] instr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] cause;
    logic          trap;
    logic          done;
    logic          fp;
    logic [4:0]    rd;
  } ent_t;

  ent_t q[$];
  bit   m_ovf, m_orph;

  bp_nonsynth_commit_aligner #(
    .vaddr_width_p(VA), .instr_width_p(IW), .dword_width_p(DW), .els_p(ELS)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .commit_v_i(commit_v_i), .commit_pc_i(commit_pc_i), .commit_instr_i(commit_instr_i),
    .commit_rd_w_v_i(commit_rd_w_v_i), .commit_fp_i(commit_fp_i), .commit_rd_addr_i(commit_rd_addr_i),
    .interrupt_v_i(interrupt_v_i), .cause_i(cause_i),
    .int_wb_v_i(int_wb_v_i), .int_wb_addr_i(int_wb_addr_i), .int_wb_data_i(int_wb_data_i),
    .fp_wb_v_i(fp_wb_v_i), .fp_wb_addr_i(fp_wb_addr_i), .fp_wb_data_i(fp_wb_data_i),
    .rec_v_o(rec_v_o), .rec_ready_i(rec_ready_i),
    .rec_pc_o(rec_pc_o), .rec_instr_o(rec_instr_o), .rec_wdata_o(rec_wdata_o),
    .rec_trap_o(rec_trap_o), .rec_cause_o(rec_cause_o),
    .full_o(full_o), .overflow_o(overflow_o), .orphan_o(orphan_o)
  );

  always #5 clk_i = ~clk_i;

  // Writeback goes to the oldest waiting entry of that file/register, else to this cycle's new entry.
  task automatic wb_model(input bit fp, input logic [4:0] a, input logic [DW-1:0] d,
                          input bit has_new, inout ent_t n);
    bit found = 0;
    foreach (q[i]) begin
      if (!found && !q[i].done && q[i].fp == fp && q[i].rd == a) begin
        q[i].done = 1'b1;
        q[i].wdata = d;
        found = 1;
      end
    end
    if (!found && has_new && !n.done && n.fp == fp && n.rd == a) begin
      n.done = 1'b1;
      n.wdata = d;
      found = 1;
    end
    if (!found) m_orph = 1;
  endtask

  // Advance the model with the inputs present before the edge, then move past the edge.
  task automatic tick();
    ent_t n = '0;
    bit has_new = 0;
    bit rv = (q.size() > 0) && q[0].done;
    if (!reset_i) begin
      q.delete();
      m_ovf = 0;
      m_orph = 0;
    end else begin
      if (commit_v_i || interrupt_v_i) begin
        if (q.size() == ELS) m_ovf = 1;
        else begin
          has_new = 1;
          n.pc = commit_pc_i;
          n.instr = commit_instr_i;
          n.trap = interrupt_v_i;
          n.cause = interrupt_v_i ? cause_i : 64'd0;
          n.fp = commit_fp_i;
          n.rd = commit_rd_addr_i;
          n.wdata = 64'd0;
          n.done = interrupt_v_i || !commit_rd_w_v_i || (!commit_fp_i && commit_rd_addr_i == 5'd0);
        end
      end
      if (int_wb_v_i) wb_model(1'b0, int_wb_addr_i, int_wb_data_i, has_new, n);
      if (fp_wb_v_i) wb_model(1'b1, fp_wb_addr_i, fp_wb_data_i, has_new, n);
      if (rv && rec_ready_i) void'(q.pop_front());
      if (has_new) q.push_back(n);
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    commit_v_i = 0; commit_pc_i = '0; commit_instr_i = '0; commit_rd_w_v_i = 0;
    commit_fp_i = 0; commit_rd_addr_i = '0; interrupt_v_i = 0; cause_i = '0;
    int_wb_v_i = 0; int_wb_addr_i = '0; int_wb_data_i = '0;
    fp_wb_v_i = 0; fp_wb_addr_i = '0; fp_wb_data_i = '0;
    rec_ready_i = 1;
  endtask

  task automatic do_reset();
    idle();
    reset_i = 0;
    repeat (2) tick();
    reset_i = 1;
    tick();
  endtask

  task automatic commit(input logic [VA-1:0] pc, input bit rdw, input bit fp, input logic [4:0] rd);
    commit_v_i = 1; commit_pc_i = pc; commit_instr_i = 32'h00000013;
    commit_rd_w_v_i = rdw; commit_fp_i = fp; commit_rd_addr_i = rd;
  endtask

  task automatic test_reset();
    idle();
    reset_i = 0;
    #1;
    n_checks++; if (rec_v_o !== 1'b0) $display("FAIL reset_rec_v got %b exp 0", rec_v_o); else n_pass++;
    n_checks++; if ({full_o, overflow_o, orphan_o} !== 3'b000) $display("FAIL reset_flags got %b exp 000", {full_o, overflow_o, orphan_o}); else n_pass++;
    repeat (2) tick();
    n_checks++; if ({rec_pc_o, rec_instr_o, rec_wdata_o, rec_trap_o, rec_cause_o} !== '0) $display("FAIL reset_fields got nonzero exp 0"); else n_pass++;
    reset_i = 1;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    commit(39'h0080000000, 0, 0, 5'd0);
    tick();
    idle();
    n_checks++; if (rec_v_o !== 1'b1) $display("FAIL single_v got %b exp 1", rec_v_o); else n_pass++;
    n_checks++; if (rec_pc_o !== 39'h0080000000 || rec_instr_o !== 32'h13) $display("FAIL single_pc got %h/%h exp 80000000/13", rec_pc_o, rec_instr_o); else n_pass++;
    n_checks++; if (rec_wdata_o !== 64'd0 || rec_trap_o !== 1'b0) $display("FAIL single_wdata got %h trap %b exp 0/0", rec_wdata_o, rec_trap_o); else n_pass++;
    tick();
    n_checks++; if (rec_v_o !== 1'b0) $display("FAIL single_retire got %b exp 0", rec_v_o); else n_pass++;
  endtask

  task automatic test_wait_order();
    do_reset();
    commit(39'h100, 1, 0, 5'd5);
    tick();
    commit(39'h104, 0, 0, 5'd0);
    tick();
    idle();
    for (int c = 0; c < 3; c++) begin
      n_checks++; if (rec_v_o !== 1'b0) $display("FAIL wait_blocked cycle %0d got %b exp 0", c, rec_v_o); else n_pass++;
      tick();
    end
    int_wb_v_i = 1; int_wb_addr_i = 5'd5; int_wb_data_i = 64'h1234;
    tick();
    idle();
    n_checks++; if (rec_v_o !== 1'b1 || rec_pc_o !== 39'h100 || rec_wdata_o !== 64'h1234) $display("FAIL wait_a got v=%b pc=%h wd=%h exp 1/100/1234", rec_v_o, rec_pc_o, rec_wdata_o); else n_pass++;
    tick();
    n_checks++; if (rec_v_o !== 1'b1 || rec_pc_o !== 39'h104 || rec_wdata_o !== 64'd0) $display("FAIL wait_b got v=%b pc=%h wd=%h exp 1/104/0", rec_v_o, rec_pc_o, rec_wdata_o); else n_pass++;
    tick();
    n_checks++; if (rec_v_o !== 1'b0) $display("FAIL wait_drain got %b exp 0", rec_v_o); else n_pass++;
  endtask

  task automatic test_same_cycle();
    do_reset();
    commit(39'h200, 1, 0, 5'd3);
    int_wb_v_i = 1; int_wb_addr_i = 5'd3; int_wb_data_i = 64'hAB;
    fp_wb_v_i = 1; fp_wb_addr_i = 5'd3; fp_wb_data_i = 64'hCD;
    tick();
    idle();
    n_checks++; if (rec_v_o !== 1'b1 || rec_wdata_o !== 64'hAB) $display("FAIL same_cycle got v=%b wd=%h exp 1/ab", rec_v_o, rec_wdata_o); else n_pass++;
    n_checks++; if (orphan_o !== 1'b1) $display("FAIL same_cycle_orphan got %b exp 1", orphan_o); else n_pass++;
    tick();
  endtask

  task automatic test_full_overflow();
    int got = 0;
    do_reset();
    rec_ready_i = 0;
    for (int i = 0; i < ELS; i++) begin
      commit(39'h1000 + 39'(4 * i), 0, 0, 5'd0);
      tick();
    end
    n_checks++; if (full_o !== 1'b1 || overflow_o !== 1'b0) $display("FAIL full_after8 got full=%b ovf=%b exp 1/0", full_o, overflow_o); else n_pass++;
    commit(39'h2000, 0, 0, 5'd0);
    tick();
    idle();
    rec_ready_i = 0;
    n_checks++; if (overflow_o !== 1'b1 || full_o !== 1'b1) $display("FAIL overflow got ovf=%b full=%b exp 1/1", overflow_o, full_o); else n_pass++;
    n_checks++; if (rec_pc_o !== 39'h1000) $display("FAIL full_hold got %h exp 1000", rec_pc_o); else n_pass++;
    rec_ready_i = 1;
    for (int c = 0; c < 20; c++) begin
      if (rec_v_o) begin
        n_checks++; if (rec_pc_o !== 39'h1000 + 39'(4 * got)) $display("FAIL drain_order got %h exp %h", rec_pc_o, 39'h1000 + 39'(4 * got)); else n_pass++;
        got++;
      end
      tick();
    end
    n_checks++; if (got != ELS) $display("FAIL drain_count got %0d exp %0d", got, ELS); else n_pass++;
    n_checks++; if (full_o !== 1'b0) $display("FAIL drain_full got %b exp 0", full_o); else n_pass++;
  endtask

  task automatic test_trap();
    do_reset();
    interrupt_v_i = 1; cause_i = 64'h8000000000000007;
    tick();
    idle();
    n_checks++; if (rec_v_o !== 1'b1 || rec_trap_o !== 1'b1) $display("FAIL trap_v got v=%b trap=%b exp 1/1", rec_v_o, rec_trap_o); else n_pass++;
    n_checks++; if (rec_cause_o !== 64'h8000000000000007) $display("FAIL trap_cause got %h exp 8000000000000007", rec_cause_o); else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    commit(39'h400, 1, 0, 5'd7);
    tick();
    commit(39'h404, 1, 1, 5'd8);
    tick();
    idle();
    reset_i = 0;
    #1;
    n_checks++; if ({rec_v_o, full_o, overflow_o, orphan_o} !== 4'b0000 || {rec_pc_o, rec_wdata_o, rec_cause_o} !== '0) $display("FAIL midreset_outputs got v=%b pc=%h exp 0", rec_v_o, rec_pc_o); else n_pass++;
    repeat (2) tick();
    reset_i = 1;
    int_wb_v_i = 1; int_wb_addr_i = 5'd7; int_wb_data_i = 64'h55;
    tick();
    idle();
    for (int c = 0; c < 3; c++) begin
      n_checks++; if (rec_v_o !== 1'b0) $display("FAIL midreset_stale cycle %0d got %b exp 0", c, rec_v_o); else n_pass++;
      tick();
    end
    n_checks++; if (orphan_o !== 1'b1) $display("FAIL midreset_orphan got %b exp 1", orphan_o); else n_pass++;
    commit(39'h300, 0, 0, 5'd0);
    tick();
    idle();
    n_checks++; if (rec_v_o !== 1'b1 || rec_pc_o !== 39'h300) $display("FAIL midreset_first got v=%b pc=%h exp 1/300", rec_v_o, rec_pc_o); else n_pass++;
    tick();
  endtask

  task automatic test_random();
    ent_t h;
    bit   e_v;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      commit_v_i = ($urandom_range(0, 1) == 1);
      interrupt_v_i = ($urandom_range(0, 19) == 0);
      commit_pc_i = {7'd0, $urandom};
      commit_instr_i = $urandom;
      commit_rd_w_v_i = ($urandom_range(0, 9) < 7);
      commit_fp_i = ($urandom_range(0, 9) < 3);
      commit_rd_addr_i = 5'($urandom_range(0, 3));
      cause_i = {$urandom, $urandom};
      int_wb_v_i = ($urandom_range(0, 9) < 3);
      int_wb_addr_i = 5'($urandom_range(0, 3));
      int_wb_data_i = {$urandom, $urandom};
      fp_wb_v_i = ($urandom_range(0, 9) < 3);
      fp_wb_addr_i = 5'($urandom_range(0, 3));
      fp_wb_data_i = {$urandom, $urandom};
      rec_ready_i = ($urandom_range(0, 9) < 6);
      tick();
      e_v = (q.size() > 0) && q[0].done;
      h = e_v ? q[0] : '0;
      n_checks++; if (rec_v_o !== e_v) $display("FAIL rand_v cycle %0d got %b exp %b", c, rec_v_o, e_v); else n_pass++;
      n_checks++;
      if ({rec_pc_o, rec_instr_o, rec_wdata_o, rec_trap_o, rec_cause_o} !== {h.pc, h.instr, h.wdata, h.trap, h.cause})
        $display("FAIL rand_rec cycle %0d got pc=%h wd=%h trap=%b exp pc=%h wd=%h trap=%b", c, rec_pc_o, rec_wdata_o, rec_trap_o, h.pc, h.wdata, h.trap);
      else n_pass++;
      n_checks++; if ({full_o, overflow_o, orphan_o} !== {q.size() == ELS, m_ovf, m_orph}) $display("FAIL rand_flags cycle %0d got %b exp %b", c, {full_o, overflow_o, orphan_o}, {q.size() == ELS, m_ovf, m_orph}); else n_pass++;
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_wait_order();
    test_same_cycle();
    test_full_overflow();
    test_trap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
